fetch_sequencer: RTL and testbench

Control sequencer for the instruction-fetch stage. It owns the PC write enable, the PC source select `{Jump, Branch}` and the redirect target, and it drives the IF/ID register's write/flush controls. It arbitrates redirects from EX (branch) and ID (jump), load-use stalls, and a multi-cycle instruction memory. A redirect that arrives while a fetch is outstanding is buffered and applied once the memory completes.

---
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage sequencer: PC enable/select, redirect buffering, IF/ID flush control
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  StallReq,
    input  logic                  BranchTaken,
    input  logic [ADDR_WIDTH-1:0] BranchDest,
    input  logic                  JumpTaken,
    input  logic [ADDR_WIDTH-1:0] JumpDest,
    input  logic                  MemReady,
    output logic                  WriteEnable,
    output logic                  Jump,
    output logic                  Branch,
    output logic [ADDR_WIDTH-1:0] Target,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic [15:0]           StallCount,
    output logic [15:0]           FlushCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t                  state;
    logic [2:0]              cnt;
    logic [ADDR_WIDTH-1:0]   pending_dest;
    logic                    pending_jump;

    logic                    redir_req;
    logic                    redir_jump;
    logic [ADDR_WIDTH-1:0]   redir_dest;
    logic                    sel_jump;
    logic [ADDR_WIDTH-1:0]   sel_dest;
    logic                    apply;

    // The branch is the older instruction, so it always wins over a jump.
    // In WAIT a jump may only replace a buffered jump, never a buffered branch.
    always_comb begin
        redir_req  = BranchTaken | JumpTaken;
        redir_jump = ~BranchTaken;
        redir_dest = BranchTaken ? BranchDest : JumpDest;
        sel_jump   = redir_jump;
        sel_dest   = redir_dest;
        if (state == WAIT) begin
            sel_jump = pending_jump;
            sel_dest = pending_dest;
            if (BranchTaken) begin
                sel_jump = 1'b0;
                sel_dest = BranchDest;
            end else if (JumpTaken && pending_jump) begin
                sel_jump = 1'b1;
                sel_dest = JumpDest;
            end
        end
        apply = MemReady & ((state == WAIT) | redir_req);
    end

    always_comb begin
        WriteEnable = 1'b0;
        IFIDWrite   = 1'b0;
        IFIDFlush   = 1'b0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        Target      = '0;
        if (Reset) begin
            IFIDFlush = 1'b1;
        end else if (apply) begin
            WriteEnable = 1'b1;
            IFIDWrite   = 1'b1;
            IFIDFlush   = 1'b1;
            Jump        = sel_jump;
            Branch      = ~sel_jump;
            Target      = sel_dest;
        end else begin
            case (state)
                WAIT: begin
                end
                FLUSH: begin
                    WriteEnable = MemReady;
                    IFIDWrite   = 1'b1;
                    IFIDFlush   = 1'b1;
                end
                default: begin
                    WriteEnable = MemReady & ~StallReq;
                    IFIDWrite   = MemReady & ~StallReq;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= RUN;
            cnt          <= '0;
            pending_dest <= '0;
            pending_jump <= 1'b0;
        end else if (apply) begin
            cnt          <= CNT_RELOAD;
            state        <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            pending_dest <= '0;
            pending_jump <= 1'b0;
        end else if (state != WAIT && redir_req) begin
            // Memory busy: park the redirect until the outstanding fetch returns.
            pending_dest <= redir_dest;
            pending_jump <= redir_jump;
            state        <= WAIT;
        end else begin
            case (state)
                WAIT: begin
                    pending_dest <= sel_dest;
                    pending_jump <= sel_jump;
                end
                FLUSH: begin
                    if (MemReady) begin
                        if (cnt <= 3'd1) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                default: state <= StallReq ? STALL : RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!WriteEnable && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (IFIDFlush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (FLUSH_CYCLES=3 and 1)
module tb_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        StallReq = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchDest = '0;
    logic        JumpTaken = 1'b0;
    logic [31:0] JumpDest = '0;
    logic        MemReady = 1'b1;

    logic        we3, j3, b3, iw3, fl3;
    logic [31:0] t3;
    logic [15:0] sc3, fc3;
    logic        we1, j1, b1, iw1, fl1;
    logic [31:0] t1;
    logic [15:0] sc1, fc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    fetch_sequencer #(.FLUSH_CYCLES(3), .ADDR_WIDTH(32)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .StallReq(StallReq),
        .BranchTaken(BranchTaken), .BranchDest(BranchDest),
        .JumpTaken(JumpTaken), .JumpDest(JumpDest), .MemReady(MemReady),
        .WriteEnable(we3), .Jump(j3), .Branch(b3), .Target(t3),
        .IFIDWrite(iw3), .IFIDFlush(fl3), .StallCount(sc3), .FlushCount(fc3)
    );

    fetch_sequencer #(.FLUSH_CYCLES(1), .ADDR_WIDTH(32)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .StallReq(StallReq),
        .BranchTaken(BranchTaken), .BranchDest(BranchDest),
        .JumpTaken(JumpTaken), .JumpDest(JumpDest), .MemReady(MemReady),
        .WriteEnable(we1), .Jump(j1), .Branch(b1), .Target(t1),
        .IFIDWrite(iw1), .IFIDFlush(fl1), .StallCount(sc1), .FlushCount(fc1)
    );

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle();
        StallReq    = 1'b0;
        BranchTaken = 1'b0;
        JumpTaken   = 1'b0;
        BranchDest  = '0;
        JumpDest    = '0;
        MemReady    = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // vector order: {WriteEnable, IFIDWrite, IFIDFlush, Jump, Branch}
    task automatic test_reset();
        idle();
        Reset = 1'b1;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b00100) begin
            n_fail++; $display("FAIL reset_ctrl3 got=%b exp=00100", {we3, iw3, fl3, j3, b3});
        end
        n_tests++;
        if (t3 !== 32'h0) begin n_fail++; $display("FAIL reset_target got=%h exp=0", t3); end
        n_tests++;
        if ({we1, iw1, fl1, j1, b1} !== 5'b00100) begin
            n_fail++; $display("FAIL reset_ctrl1 got=%b exp=00100", {we1, iw1, fl1, j1, b1});
        end
        n_tests++;
        if ({sc3, fc3} !== 32'h0) begin n_fail++; $display("FAIL reset_counts got=%h exp=0", {sc3, fc3}); end
        tick();
        Reset = 1'b0;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b11000) begin
            n_fail++; $display("FAIL reset_release got=%b exp=11000", {we3, iw3, fl3, j3, b3});
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        BranchTaken = 1'b1; BranchDest = 32'h40;
        JumpTaken   = 1'b1; JumpDest   = 32'h80;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b11101) begin
            n_fail++; $display("FAIL prio_ctrl got=%b exp=11101", {we3, iw3, fl3, j3, b3});
        end
        n_tests++;
        if (t3 !== 32'h40) begin n_fail++; $display("FAIL prio_target got=%h exp=40", t3); end
        tick();
        idle();
        #1;
        n_tests++;
        if ({j3, b3, t3} !== 34'h0) begin
            n_fail++; $display("FAIL prio_target_idle got=%b/%b/%h exp=0/0/0", j3, b3, t3);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        StallReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({we3, iw3, we1, iw1} !== 4'b0000) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got=%b exp=0000", i, {we3, iw3, we1, iw1});
            end
            tick();
        end
        StallReq = 1'b0;
        #1;
        n_tests++;
        if ({we3, iw3} !== 2'b11) begin n_fail++; $display("FAIL stall_release got=%b exp=11", {we3, iw3}); end
        n_tests++;
        if (sc3 !== (PERF ? 16'd3 : 16'd0)) begin
            n_fail++; $display("FAIL stall_count got=%0d exp=%0d", sc3, PERF ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_wait_jump();
        do_reset();
        MemReady = 1'b0; JumpTaken = 1'b1; JumpDest = 32'h100;
        #1;
        n_tests++;
        if ({we3, iw3, j3, b3, t3} !== 36'h0) begin
            n_fail++; $display("FAIL wait_latch got=%b%b%b%b/%h exp=0000/0", we3, iw3, j3, b3, t3);
        end
        tick();
        JumpTaken = 1'b0; JumpDest = '0;
        #1;
        n_tests++;
        if ({we3, iw3} !== 2'b00) begin n_fail++; $display("FAIL wait_hold got=%b exp=00", {we3, iw3}); end
        tick();
        MemReady = 1'b1;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b11110 || t3 !== 32'h100) begin
            n_fail++; $display("FAIL wait_apply got=%b/%h exp=11110/100", {we3, iw3, fl3, j3, b3}, t3);
        end
        tick();
    endtask

    task automatic test_wait_override();
        do_reset();
        MemReady = 1'b0; JumpTaken = 1'b1; JumpDest = 32'h100;
        tick();
        JumpTaken = 1'b0; BranchTaken = 1'b1; BranchDest = 32'h200;
        #1;
        n_tests++;
        if (we3 !== 1'b0) begin n_fail++; $display("FAIL ovr_hold got=%b exp=0", we3); end
        tick();
        BranchTaken = 1'b0; MemReady = 1'b1;
        #1;
        n_tests++;
        if ({j3, b3} !== 2'b01 || t3 !== 32'h200) begin
            n_fail++; $display("FAIL ovr_branch got=%b/%h exp=01/200", {j3, b3}, t3);
        end
        do_reset();
        MemReady = 1'b0; BranchTaken = 1'b1; BranchDest = 32'h300;
        tick();
        BranchTaken = 1'b0; JumpTaken = 1'b1; JumpDest = 32'h400;
        tick();
        JumpTaken = 1'b0; MemReady = 1'b1;
        #1;
        n_tests++;
        if ({j3, b3} !== 2'b01 || t3 !== 32'h300) begin
            n_fail++; $display("FAIL ovr_keep_branch got=%b/%h exp=01/300", {j3, b3}, t3);
        end
        tick();
    endtask

    task automatic test_flush_stall();
        do_reset();
        BranchTaken = 1'b1; BranchDest = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({we3, iw3, fl3} !== 3'b111) begin
                n_fail++; $display("FAIL flush_bubble cyc=%0d got=%b exp=111", i, {we3, iw3, fl3});
            end
            if (i == 1) begin
                n_tests++;
                if ({we1, fl1} !== 2'b00) begin
                    n_fail++; $display("FAIL flush1_stall got=%b exp=00", {we1, fl1});
                end
            end
            tick();
            BranchTaken = 1'b0; StallReq = 1'b1;
        end
        #1;
        n_tests++;
        if ({we3, fl3} !== 2'b00) begin n_fail++; $display("FAIL flush_end got=%b exp=00", {we3, fl3}); end
        n_tests++;
        if (fc3 !== (PERF ? 16'd3 : 16'd0)) begin
            n_fail++; $display("FAIL flush_count got=%0d exp=%0d", fc3, PERF ? 3 : 0);
        end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        BranchTaken = 1'b1; BranchDest = 32'h20;
        tick();
        idle();
        Reset = 1'b1;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b00100 || t3 !== 32'h0) begin
            n_fail++; $display("FAIL async_assert got=%b/%h exp=00100/0", {we3, iw3, fl3, j3, b3}, t3);
        end
        #2;
        Reset = 1'b0;
        #1;
        n_tests++;
        if ({we3, iw3, fl3, j3, b3} !== 5'b11000) begin
            n_fail++; $display("FAIL async_release got=%b exp=11000", {we3, iw3, fl3, j3, b3});
        end
        tick();
    endtask

    // Reference model: per instance, a "waiting" flag with its buffered redirect and the
    // number of bubble loads still owed after the last applied redirect.
    task automatic test_random();
        logic        m_wait[2];
        logic        m_pj[2];
        logic [31:0] m_pd[2];
        int          m_left[2];
        int          m_sc[2];
        int          m_fc[2];
        logic        ap[2];
        logic        cj[2];
        logic [31:0] cd[2];
        logic [4:0]  ev[2];
        logic [31:0] et[2];
        logic [4:0]  av;
        logic [31:0] at;
        logic [15:0] asc, afc;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 1'b0; m_pj[k] = 1'b0; m_pd[k] = '0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            Reset       = ($urandom_range(63) == 0);
            StallReq    = ($urandom_range(3) == 0);
            BranchTaken = ($urandom_range(7) == 0);
            JumpTaken   = ($urandom_range(7) == 0);
            MemReady    = ($urandom_range(3) != 0);
            BranchDest  = $urandom;
            JumpDest    = $urandom;
            #1;
            for (int k = 0; k < 2; k++) begin
                if (Reset) begin
                    m_wait[k] = 1'b0; m_pj[k] = 1'b0; m_pd[k] = '0; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
                end
                ap[k] = 1'b0; ev[k] = 5'b00000; et[k] = '0;
                if (m_wait[k]) begin
                    cj[k] = m_pj[k]; cd[k] = m_pd[k];
                    if (BranchTaken) begin cj[k] = 1'b0; cd[k] = BranchDest; end
                    else if (JumpTaken && m_pj[k]) begin cj[k] = 1'b1; cd[k] = JumpDest; end
                    ap[k] = MemReady;
                end else begin
                    cj[k] = !BranchTaken;
                    cd[k] = BranchTaken ? BranchDest : JumpDest;
                    ap[k] = MemReady && (BranchTaken || JumpTaken);
                end
                if (Reset) begin
                    ev[k] = 5'b00100; ap[k] = 1'b0;
                end else if (ap[k]) begin
                    ev[k] = {3'b111, cj[k], !cj[k]}; et[k] = cd[k];
                end else if (m_wait[k]) begin
                    ev[k] = 5'b00000;
                end else if (m_left[k] > 0) begin
                    ev[k] = {MemReady, 2'b11, 2'b00};
                end else begin
                    ev[k] = {MemReady && !StallReq, MemReady && !StallReq, 3'b000};
                end
                av  = (k == 0) ? {we3, iw3, fl3, j3, b3} : {we1, iw1, fl1, j1, b1};
                at  = (k == 0) ? t3 : t1;
                asc = (k == 0) ? sc3 : sc1;
                afc = (k == 0) ? fc3 : fc1;
                n_tests++;
                if (av !== ev[k] || at !== et[k]) begin
                    n_fail++;
                    $display("FAIL rand_outputs inst=%0d cyc=%0d got=%b/%h exp=%b/%h", k, cyc, av, at, ev[k], et[k]);
                end
                n_tests++;
                if (asc !== (PERF ? 16'(m_sc[k]) : 16'd0) || afc !== (PERF ? 16'(m_fc[k]) : 16'd0)) begin
                    n_fail++;
                    $display("FAIL rand_counts inst=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", k, cyc, asc, afc,
                             PERF ? m_sc[k] : 0, PERF ? m_fc[k] : 0);
                end
            end
            @(posedge Clock);
            for (int k = 0; k < 2; k++) begin
                if (!Reset) begin
                    if (!ev[k][4] && m_sc[k] < 65535) m_sc[k]++;
                    if (ev[k][2] && m_fc[k] < 65535) m_fc[k]++;
                    if (ap[k]) begin
                        m_left[k] = (k == 0) ? 2 : 0;
                        m_wait[k] = 1'b0;
                    end else if (m_wait[k]) begin
                        m_pj[k] = cj[k]; m_pd[k] = cd[k];
                    end else if (BranchTaken || JumpTaken) begin
                        m_wait[k] = 1'b1; m_pj[k] = cj[k]; m_pd[k] = cd[k]; m_left[k] = 0;
                    end else if (m_left[k] > 0 && MemReady) begin
                        m_left[k]--;
                    end
                end
            end
            @(negedge Clock);
        end
        Reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        @(negedge Clock);
        test_reset();
        test_priority();
        test_stall();
        test_wait_jump();
        test_wait_override();
        test_flush_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
